// File: rtl/oled_text_renderer.sv
// Renders a latched list of 8- or 16-column glyphs onto two OLED pages.
// It fetches each column from a registered font ROM and streams command and data bytes over a valid/ready link.
module oled_text_renderer #(
  parameter int CHAR_NUM   = 8,
  parameter int START_PAGE = 0,
  parameter int START_COL  = 0
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6*CHAR_NUM-1:0] char_list,
  input  logic [CHAR_NUM-1:0]   char_wide,
  output logic [5:0]            font_sel,
  output logic                  font_row,
  output logic [8:0]            index,
  input  logic [7:0]            font_data,
  output logic                  tx_valid,
  output logic                  tx_dc,
  output logic [7:0]            tx_byte,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int          CW   = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;
  localparam logic [2:0]  P0   = 3'(START_PAGE);
  localparam logic [6:0]  SC   = 7'(START_COL);
  localparam logic [CW-1:0] LAST_CHAR = CW'(CHAR_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_PAGE, S_CMD_COL_L, S_CMD_COL_H, S_FETCH, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_row, w_row_nxt;
  logic [CW-1:0]         r_char, w_char_nxt;
  logic [3:0]            r_col, w_col_nxt;
  logic [6*CHAR_NUM-1:0] r_list;
  logic [CHAR_NUM-1:0]   r_wide;
  logic [5:0]            r_font_sel;
  logic                  r_font_row;
  logic [8:0]            r_index;
  logic                  r_tx_valid, r_tx_dc, r_busy, r_done;
  logic [7:0]            r_tx_byte;
  logic                  w_hs, w_col_last, w_char_last;
  logic [2:0]            w_page;

  assign w_hs        = r_tx_valid & tx_ready;
  assign w_col_last  = (r_col == (r_wide[r_char] ? 4'd15 : 4'd7));
  assign w_char_last = (r_char == LAST_CHAR);
  assign w_page      = P0 + {2'b00, w_row_nxt};

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_char_nxt  = r_char;
    w_col_nxt   = r_col;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CMD_PAGE;
          w_row_nxt   = 1'b0;
          w_char_nxt  = {CW{1'b0}};
          w_col_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CMD_PAGE:  if (w_hs) w_state_nxt = S_CMD_COL_L; else w_state_nxt = S_CMD_PAGE;
      S_CMD_COL_L: if (w_hs) w_state_nxt = S_CMD_COL_H; else w_state_nxt = S_CMD_COL_L;
      S_CMD_COL_H: if (w_hs) w_state_nxt = S_FETCH;     else w_state_nxt = S_CMD_COL_H;
      S_FETCH:     w_state_nxt = S_WAIT;
      S_WAIT:      w_state_nxt = S_SEND;
      S_SEND: begin
        if (!w_hs) begin
          w_state_nxt = S_SEND;
        end else if (!w_col_last) begin
          w_col_nxt   = r_col + 4'd1;
          w_state_nxt = S_FETCH;
        end else if (!w_char_last) begin
          w_col_nxt   = 4'd0;
          w_char_nxt  = r_char + {{(CW-1){1'b0}}, 1'b1};
          w_state_nxt = S_FETCH;
        end else if (!r_row) begin
          w_col_nxt   = 4'd0;
          w_char_nxt  = {CW{1'b0}};
          w_row_nxt   = 1'b1;
          w_state_nxt = S_CMD_PAGE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters and the character list snapshot taken at start.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= 1'b0;
      r_char <= {CW{1'b0}};
      r_col  <= 4'd0;
      r_list <= '0;
      r_wide <= '0;
    end else begin
      r_row  <= w_row_nxt;
      r_char <= w_char_nxt;
      r_col  <= w_col_nxt;
      if (r_state == S_IDLE && start) begin
        r_list <= char_list;
        r_wide <= char_wide;
      end else begin
        r_list <= r_list;
        r_wide <= r_wide;
      end
    end
  end

  // Registered outputs, updated on state transitions so they stay stable while stalled.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_dc    <= 1'b0;
      r_tx_byte  <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_font_sel <= 6'd0;
      r_font_row <= 1'b0;
      r_index    <= 9'd0;
    end else if (r_state == S_IDLE && start) begin
      r_busy     <= 1'b1;
      r_tx_valid <= 1'b1;
      r_tx_dc    <= 1'b0;
      r_tx_byte  <= 8'hB0 | {5'd0, w_page};
    end else if (r_state == S_SEND && w_state_nxt == S_CMD_PAGE) begin
      r_tx_valid <= 1'b1;
      r_tx_dc    <= 1'b0;
      r_tx_byte  <= 8'hB0 | {5'd0, w_page};
    end else if (r_state == S_CMD_PAGE && w_hs) begin
      r_tx_byte  <= {4'h0, SC[3:0]};
    end else if (r_state == S_CMD_COL_L && w_hs) begin
      r_tx_byte  <= {5'b00010, SC[6:4]};
    end else if (w_state_nxt == S_FETCH && r_state != S_FETCH) begin
      // ROM address is presented from FETCH onward and held through SEND.
      r_tx_valid <= 1'b0;
      r_font_sel <= r_list[6*w_char_nxt +: 6];
      r_font_row <= w_row_nxt;
      r_index    <= {5'd0, w_col_nxt};
    end else if (r_state == S_WAIT) begin
      r_tx_valid <= 1'b1;
      r_tx_dc    <= 1'b1;
      r_tx_byte  <= font_data;
    end else if (r_state == S_SEND && w_state_nxt == S_DONE) begin
      r_tx_valid <= 1'b0;
      r_done     <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_valid <= r_tx_valid;
      r_done     <= r_done;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_dc    = r_tx_dc;
  assign tx_byte  = r_tx_byte;
  assign busy     = r_busy;
  assign done     = r_done;
  assign font_sel = r_font_sel;
  assign font_row = r_font_row;
  assign index    = r_index;

endmodule

// File: tb/tb_oled_text_renderer.sv
// Directed bench for oled_text_renderer: a byte-list reference model plus a per-cycle output checker.
module tb_oled_text_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, tx_ready, sel;
  logic [11:0] cl_a;
  logic [1:0]  cw_a;
  logic [5:0]  cl_b;
  logic [0:0]  cw_b;
  logic        start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic [5:0] a_sel, b_sel;
  logic       a_row, b_row, a_valid, b_valid, a_dc, b_dc, a_busy, b_busy, a_done, b_done;
  logic [8:0] a_idx, b_idx;
  logic [7:0] a_byte, b_byte, rom_a, rom_b;

  oled_text_renderer #(.CHAR_NUM(2), .START_PAGE(2), .START_COL(16)) dut_a (
    .sys_clk(clk), .rst_n(rst_n), .start(start_a), .char_list(cl_a), .char_wide(cw_a),
    .font_sel(a_sel), .font_row(a_row), .index(a_idx), .font_data(rom_a),
    .tx_valid(a_valid), .tx_dc(a_dc), .tx_byte(a_byte), .tx_ready(tx_ready),
    .busy(a_busy), .done(a_done));

  oled_text_renderer #(.CHAR_NUM(1), .START_PAGE(7), .START_COL(0)) dut_b (
    .sys_clk(clk), .rst_n(rst_n), .start(start_b), .char_list(cl_b), .char_wide(cw_b),
    .font_sel(b_sel), .font_row(b_row), .index(b_idx), .font_data(rom_b),
    .tx_valid(b_valid), .tx_dc(b_dc), .tx_byte(b_byte), .tx_ready(tx_ready),
    .busy(b_busy), .done(b_done));

  // Font ROM stand-ins: one register stage behind the address.
  always @(posedge clk) begin
    rom_a <= {a_row, a_sel[2:0], a_idx[3:0]};
    rom_b <= {b_row, b_sel[2:0], b_idx[3:0]};
  end

  logic       m_valid, m_dc, m_busy, m_done;
  logic [7:0] m_byte;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_dc    = sel ? b_dc    : a_dc;
  assign m_byte  = sel ? b_byte  : a_byte;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;

  int total = 0, bad = 0;
  int cyc = 0, last_data = -100, data_seen = 0, done_cnt = 0, stall_cnt = 0, mode = 0;
  logic chk_on = 1'b0;
  logic [8:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected frame: page/column commands then each glyph column, for both rows.
  task automatic build(input int pg, input int sc, input int n, input logic [47:0] cl, input logic [7:0] cw);
    for (int r = 0; r < 2; r++) begin
      expq.push_back({1'b0, 8'hB0 | 8'((pg + r) % 8)});
      expq.push_back({1'b0, 8'(sc % 16)});
      expq.push_back({1'b0, 8'h10 | 8'((sc / 16) % 8)});
      for (int k = 0; k < n; k++)
        for (int c = 0; c < (cw[k] ? 16 : 8); c++)
          expq.push_back({1'b1, 1'(r), cl[6*k +: 3], 4'(c)});
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tx_ready driver: always ready, random, or a 5-cycle stall on data byte 0x02.
  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      1: tx_ready = 1'($urandom_range(0, 1));
      2: begin
        if (m_valid && m_dc && m_byte == 8'h02 && stall_cnt < 5) begin
          tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          tx_ready = 1'b1;
        end
      end
      default: tx_ready = 1'b1;
    endcase
  end

  // Per-cycle compare against the expected byte queue.
  initial begin
    logic       prev_stall, prev_done, ps_dc;
    logic [7:0] ps_byte;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    ps_dc      = 1'b0;
    ps_byte    = 8'd0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (prev_stall) chk("stall_hold", 32'({m_valid, m_dc, m_byte}), 32'({1'b1, ps_dc, ps_byte}));
        if (prev_done) chk("busy_after_done", 32'(m_busy), 32'd0);
        if (m_valid) chk("busy_while_valid", 32'(m_busy), 32'd1);
        if (m_valid && tx_ready) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte actual=%0h required=none t=%0t", {m_dc, m_byte}, $time);
          end else begin
            e = expq.pop_front();
            chk("byte", 32'({m_dc, m_byte}), 32'(e));
            if (m_dc) begin
              chk("data_gap_ge3", 32'(cyc - last_data >= 3), 32'd1);
              last_data = cyc;
              data_seen++;
            end
          end
        end
        if (m_done) begin
          chk("done_all_sent", 32'(expq.size()), 32'd0);
          done_cnt++;
        end
        prev_stall = m_valid && !tx_ready;
        ps_dc      = m_dc;
        ps_byte    = m_byte;
        prev_done  = m_done;
      end else begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the falling edge inside the done cycle, or flags a timeout.
  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (m_done) break;
    end
    if (!m_done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic run_frame(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    pulse_start();
    wait_done(name, budget);
    @(posedge clk);
    #1;
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_queue_empty"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int d0, base;
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1; sel = 1'b0;
    cl_a = {6'd4, 6'd0}; cw_a = 2'b10; cl_b = 6'd13; cw_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_a", 32'({a_valid, a_dc, a_byte, a_busy, a_done, a_sel, a_row, a_idx}), 32'd0);
    chk("reset_outputs_b", 32'({b_valid, b_dc, b_byte, b_busy, b_done, b_sel, b_row, b_idx}), 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Scenario 1 with literal pins on the model.
    build(2, 16, 2, {36'd0, cl_a}, {6'd0, cw_a});
    chk("model_len", 32'(expq.size()), 32'd54);
    chk("model_first", 32'(expq[0]), 32'h0B2);
    chk("model_colh", 32'(expq[2]), 32'h011);
    chk("model_wide0", 32'(expq[11]), 32'h140);
    chk("model_page1", 32'(expq[27]), 32'h0B3);
    chk("model_last", 32'(expq[53]), 32'h1CF);
    run_frame("s1", 500);

    // Scenario 2: stall on the third data byte.
    mode = 2; stall_cnt = 0;
    build(2, 16, 2, {36'd0, cl_a}, {6'd0, cw_a});
    run_frame("s2", 500);
    chk("s2_stall_cycles", 32'(stall_cnt), 32'd5);
    mode = 0;

    // Scenario 3: start mid-frame and during DONE are ignored; start right after DONE is honoured.
    build(2, 16, 2, {36'd0, cl_a}, {6'd0, cw_a});
    pulse_start();
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("s3a", 500);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("s3_idle_busy", 32'(a_busy), 32'd0);
    build(2, 16, 2, {36'd0, cl_a}, {6'd0, cw_a});
    pulse_start();
    wait_done("s3b", 500);
    build(2, 16, 2, {36'd0, cl_a}, {6'd0, cw_a});
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("s3c", 500);
    @(posedge clk);
    #1 chk("s3_queue_empty", 32'(expq.size()), 32'd0);

    // Scenario 4: reset while the 10th data byte is offered.
    build(2, 16, 2, {36'd0, cl_a}, {6'd0, cw_a});
    base = data_seen;
    pulse_start();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (data_seen - base >= 9 && m_valid && m_dc) break;
    end
    chk("s4_reached_byte10", 32'(data_seen - base), 32'd9);
    chk_on = 1'b0;
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 chk("s4_async_reset", 32'({a_valid, a_dc, a_byte, a_busy, a_done, a_sel, a_row, a_idx}), 32'd0);
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("s4_no_done", 32'(done_cnt - d0), 32'd0);
    chk("s4_idle", 32'({a_valid, a_busy}), 32'd0);

    // Scenario 5: page wrap 7 -> 0 on the single-character instance.
    sel = 1'b1;
    build(7, 0, 1, {42'd0, cl_b}, {7'd0, cw_b});
    chk("model5_len", 32'(expq.size()), 32'd22);
    chk("model5_data", 32'(expq[3]), 32'h150);
    chk("model5_wrap", 32'(expq[11]), 32'h0B0);
    chk("model5_last", 32'(expq[21]), 32'h1D7);
    run_frame("s5", 300);
    sel = 1'b0;

    // Scenario 6: random codes, widths and backpressure.
    mode = 1;
    for (int f = 0; f < 20; f++) begin
      cl_a = 12'($urandom);
      cw_a = 2'($urandom);
      build(2, 16, 2, {36'd0, cl_a}, {6'd0, cw_a});
      run_frame("s6", 3000);
    end
    mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
